// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT sequencer and its datapath neighbours.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

    localparam int DEF_STAGES = 3;
    localparam int DEF_GROUPS = 2;
    localparam int DEF_ROT_W  = 3;
    localparam int DATA_W     = 34;   // 17-bit real + 17-bit imag
    localparam int FRAME_W    = 136;

    // Counter width that stays legal when a dimension collapses to one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Control bundle between the FFT sequencer (master) and the s_p/mux/butterfly/reg1/p_s datapath (slave).
interface fft_seq_ctrl_if
    import fft_pkg::*;
#(
    parameter int STAGES = DEF_STAGES,
    parameter int GROUPS = DEF_GROUPS,
    parameter int ROT_W  = DEF_ROT_W
);
    localparam int STG_W = idx_w(STAGES);

    logic             frame_rdy;
    logic             ps_busy;
    logic             mux_sel;
    logic [ROT_W-1:0] rotation;
    logic             reg_we;
    logic             ps_load;
    logic             busy;
    logic             done;
    logic [STG_W-1:0] stage_idx;
    logic             ovf;

    modport master (
        input  frame_rdy, ps_busy,
        output mux_sel, rotation, reg_we, ps_load, busy, done, stage_idx, ovf
    );

    modport slave (
        output frame_rdy, ps_busy,
        input  mux_sel, rotation, reg_we, ps_load, busy, done, stage_idx, ovf
    );

endinterface

// File: rtl/fft_rot_gen.sv
// Twiddle index for the butterfly: (grp << stage) mod 2^ROT_W, negated mod 2^ROT_W for the inverse transform.
module fft_rot_gen #(
    parameter int STG_W = 2,
    parameter int GRP_W = 1,
    parameter int ROT_W = 3
) (
    input  logic [STG_W-1:0] stage,
    input  logic [GRP_W-1:0] grp,
    input  logic             inverse,
    output logic [ROT_W-1:0] rotation
);

    logic [ROT_W-1:0] fwd;

    // Shifting inside ROT_W bits gives the modulo for free.
    assign fwd      = ROT_W'(grp) << stage;
    assign rotation = inverse ? ({ROT_W{1'b0}} - fwd) : fwd;

endmodule

// File: rtl/fft_seq_ctrl.sv
// Stage/group sequencer for the shared FFT butterfly.
// Optional FFT_SEQ_INVERSE_EN adds an 'inverse' input selecting conjugate twiddles per frame.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int STAGES = DEF_STAGES,
    parameter int GROUPS = DEF_GROUPS,
    parameter int ROT_W  = DEF_ROT_W
) (
    input  logic clk,
    input  logic rst,
`ifdef FFT_SEQ_INVERSE_EN
    input  logic inverse,
`endif
    fft_seq_ctrl_if.master bus
);

    localparam int STG_W = idx_w(STAGES);
    localparam int GRP_W = idx_w(GROUPS);

    seq_state_t       state_reg, state_next;
    logic [STG_W-1:0] stage_reg, stage_next;
    logic [GRP_W-1:0] grp_reg,   grp_next;
    logic             ovf_reg,   ovf_next;
    logic             inv_reg,   inv_next;
    logic             inv_in;
    logic             last_pass;
    logic             accept;
    logic             reg_we;
    logic             ps_load;

`ifdef FFT_SEQ_INVERSE_EN
    assign inv_in = inverse;
`else
    assign inv_in = 1'b0;
`endif

    assign last_pass = (stage_reg == STG_W'(STAGES - 1)) && (grp_reg == GRP_W'(GROUPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            stage_reg <= '0;
            grp_reg   <= '0;
            ovf_reg   <= 1'b0;
            inv_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            stage_reg <= stage_next;
            grp_reg   <= grp_next;
            ovf_reg   <= ovf_next;
            inv_reg   <= inv_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        grp_next   = grp_reg;
        inv_next   = inv_reg;
        reg_we     = 1'b0;
        ps_load    = 1'b0;
        accept     = 1'b0;

        case (state_reg)
            IDLE: begin
                accept = 1'b1;
            end
            RUN: begin
                if (!last_pass) begin
                    reg_we = 1'b1;
                    if (grp_reg == GRP_W'(GROUPS - 1)) begin
                        grp_next   = '0;
                        stage_next = stage_reg + STG_W'(1);
                    end else begin
                        grp_next   = grp_reg + GRP_W'(1);
                    end
                end else if (!bus.ps_busy) begin
                    ps_load = 1'b1;
                    accept  = 1'b1;
                end else begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!bus.ps_busy) begin
                    ps_load = 1'b1;
                    accept  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Frame finished: park counters at zero so idle outputs read as zero.
        if (ps_load) begin
            state_next = IDLE;
            stage_next = '0;
            grp_next   = '0;
        end

        if (accept && bus.frame_rdy) begin
            state_next = RUN;
            stage_next = '0;
            grp_next   = '0;
            inv_next   = inv_in;
        end

        ovf_next = ovf_reg | (bus.frame_rdy & ~accept);
    end

    fft_rot_gen #(
        .STG_W (STG_W),
        .GRP_W (GRP_W),
        .ROT_W (ROT_W)
    ) u_rot_gen (
        .stage    (stage_reg),
        .grp      (grp_reg),
        .inverse  (inv_reg),
        .rotation (bus.rotation)
    );

    assign bus.busy      = (state_reg != IDLE);
    assign bus.mux_sel   = (state_reg != IDLE) && (stage_reg != '0);
    assign bus.reg_we    = reg_we;
    assign bus.ps_load   = ps_load;
    assign bus.done      = ps_load;
    assign bus.stage_idx = stage_reg;
    assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Bench for fft_seq_ctrl: directed scenarios then random frame_rdy/ps_busy/rst traffic against a pass-count model.
module tb_fft_seq_ctrl;

    localparam int STAGES = 3;
    localparam int GROUPS = 2;
    localparam int ROT_W  = 3;
    localparam int NPASS  = STAGES * GROUPS;
    localparam int ROT_M  = 1 << ROT_W;

    logic clk;
    logic rst;
`ifdef FFT_SEQ_INVERSE_EN
    logic inverse;
`endif

    fft_seq_ctrl_if #(.STAGES(STAGES), .GROUPS(GROUPS), .ROT_W(ROT_W)) bus ();

    fft_seq_ctrl #(.STAGES(STAGES), .GROUPS(GROUPS), .ROT_W(ROT_W)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef FFT_SEQ_INVERSE_EN
        .inverse (inverse),
`endif
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: k = -1 when idle, otherwise index of the current butterfly pass.
    int k       = -1;
    bit m_ovf   = 1'b0;
    bit m_inv   = 1'b0;
    bit m_valid = 1'b0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit fr, input bit pb, input bit rs, input bit iv);
        bit e_busy, e_last, e_load, e_accept;
        int e_st, e_gp, e_rot;
        bus.frame_rdy = fr;
        bus.ps_busy   = pb;
        rst           = rs;
`ifdef FFT_SEQ_INVERSE_EN
        inverse       = iv;
`endif
        #1;
        e_busy   = (k >= 0);
        e_st     = e_busy ? k / GROUPS : 0;
        e_gp     = e_busy ? k % GROUPS : 0;
        e_rot    = (e_gp << e_st) % ROT_M;
        if (m_inv) e_rot = (ROT_M - e_rot) % ROT_M;
        e_last   = (k == NPASS - 1);
        e_load   = e_last && !pb;
        e_accept = !e_busy || e_load;
        if (m_valid) begin
            check_eq("busy",      int'(bus.busy),      int'(e_busy));
            check_eq("mux_sel",   int'(bus.mux_sel),   int'(e_busy && e_st != 0));
            check_eq("rotation",  int'(bus.rotation),  e_rot);
            check_eq("reg_we",    int'(bus.reg_we),    int'(e_busy && !e_last));
            check_eq("ps_load",   int'(bus.ps_load),   int'(e_load));
            check_eq("done",      int'(bus.done),      int'(e_load));
            check_eq("stage_idx", int'(bus.stage_idx), e_st);
            check_eq("ovf",       int'(bus.ovf),       int'(m_ovf));
            if (e_load && !rs)
                $display("cycle %0d: frame out, ps_load rot=%0d next_frame=%0b ovf=%0b",
                         cyc, e_rot, fr, m_ovf);
        end
        @(posedge clk);
        cyc++;
        if (rs) begin
            k       = -1;
            m_ovf   = 1'b0;
            m_inv   = 1'b0;
            m_valid = 1'b1;
            $display("cycle %0d: reset", cyc);
        end else begin
            if (fr && !e_accept) m_ovf = 1'b1;
            if (!e_busy) begin
                if (fr) k = 0;
            end else if (!e_last) begin
                k++;
            end else if (e_load) begin
                k = fr ? 0 : -1;
            end
            if (fr && e_accept) begin
`ifdef FFT_SEQ_INVERSE_EN
                m_inv = iv;
`else
                m_inv = 1'b0;
`endif
            end
        end
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.frame_rdy = 1'b0;
        bus.ps_busy   = 1'b0;
        rst           = 1'b1;
`ifdef FFT_SEQ_INVERSE_EN
        inverse       = 1'b0;
`endif
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle_n(2);

        // Single frame, p_s free
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle_n(8);

        // Frame whose last pass waits four cycles for p_s
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle_n(5);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        idle_n(3);

        // Back-to-back: second frame_rdy in the ps_load cycle
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle_n(5);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle_n(8);

        // Dropped frame_rdy mid-frame
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle_n(2);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle_n(6);

        // Reset mid-frame, then a fresh frame
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle_n(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle_n(2);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, ~i[0]);

        // Random traffic; inverse toggles freely to show it only matters at accept
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 79) == 0),
                 1'($urandom_range(0, 1)));
        end
        idle_n(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
